serial_adder: RTL and testbench

- Bit-serial unsigned adder for two WIDTH-bit operands, processed LSB-first, one bit per clock.
- The per-bit datapath is a registered-carry full adder built from two half_adder stages.
- Sits downstream of the combinational half_adder cell and upstream of result consumers that accept a start/done handshake.
- Trades latency (WIDTH+1 cycles) for a single 1-bit adder datapath.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 16 +
 rtl/serial_adder_full_adder.sv | 25 ++
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Bit counter must hold 0..WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake plus operand and result bus of the serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             READY;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             CARRY;

    modport master (output START, A, B, input READY, BUSY, DONE, SUM, CARRY);
    modport slave  (input START, A, B, output READY, BUSY, DONE, SUM, CARRY);
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder built from two half-adder cells; purely combinational.
module half_adder (
    input  logic A,
    input  logic B,
    output logic S,
    output logic C
);
    assign S = A ^ B;
    assign C = A & B;
endmodule

module full_adder_1b (
    input  logic A,
    input  logic B,
    input  logic CIN,
    output logic SUM,
    output logic COUT
);
    logic s0, c0, c1;

    half_adder u_ha0 (.A(A),  .B(B),   .S(s0),  .C(c0));
    half_adder u_ha1 (.A(s0), .B(CIN), .S(SUM), .C(c1));

    assign COUT = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: LSB-first, one bit per clock, registered carry.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    serial_adder_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] sha_q, shb_q, sum_q, sum_d;
    logic [WIDTH:0]   sum_ext;
    logic [CW-1:0]    cnt_q;
    logic             c_q, carry_q;
    logic             ready_q, busy_q, done_q;
    logic             fa_s, fa_co;

    full_adder_1b u_fa (
        .A    (sha_q[0]),
        .B    (shb_q[0]),
        .CIN  (c_q),
        .SUM  (fa_s),
        .COUT (fa_co)
    );

    // New bit enters at the MSB; widening first keeps WIDTH=1 legal.
    assign sum_ext = {fa_s, sum_q};
    assign sum_d   = sum_ext[WIDTH:1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    c_q   <= fa_co;
                    sum_q <= sum_d;
                    sha_q <= sha_q >> 1;
                    shb_q <= shb_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_FIN;
                        carry_q <= fa_co;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and FIN both accept; FIN -> RUN is the back-to-back path.
                    if (bus.START) begin
                        state_q <= ST_RUN;
                        sha_q   <= bus.A;
                        shb_q   <= bus.B;
                        sum_q   <= '0;
                        carry_q <= 1'b0;
                        c_q     <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.READY = ready_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.SUM   = sum_q;
    assign bus.CARRY = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    serial_adder_if #(.WIDTH(8)) ifc8 ();
    serial_adder_if #(.WIDTH(1)) ifc1 ();

    serial_adder #(.WIDTH(8)) dut8 (.CLK(CLK), .RST_N(RST_N), .bus(ifc8));
    serial_adder #(.WIDTH(1)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(ifc1));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Accept, then expect DONE exactly WIDTH edges after the accept edge.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec);
        int early;
        early = 0;
        ifc8.START = 1'b1; ifc8.A = a; ifc8.B = b;
        step();
        ifc8.START = 1'b0; ifc8.A = 8'h00; ifc8.B = 8'h00;
        chk({tag, ".busy"},    ifc8.BUSY, 1);
        chk({tag, ".ready"},   ifc8.READY, 0);
        chk({tag, ".sum_clr"}, ifc8.SUM, 0);
        for (int k = 1; k < 8; k++) begin
            step();
            if (ifc8.DONE) early++;
        end
        chk({tag, ".early"}, early, 0);
        step();
        chk({tag, ".done"},  ifc8.DONE, 1);
        chk({tag, ".sum"},   ifc8.SUM, es);
        chk({tag, ".carry"}, ifc8.CARRY, ec);
        chk({tag, ".rdy_fin"}, ifc8.READY, 1);
        step();
        chk({tag, ".done_1cyc"}, ifc8.DONE, 0);
        chk({tag, ".sum_hold"},  ifc8.SUM, es);
    endtask

    task automatic op1(input string tag, input logic a, input logic b, input logic [1:0] exp);
        ifc1.START = 1'b1; ifc1.A = a; ifc1.B = b;
        step();
        ifc1.START = 1'b0;
        chk({tag, ".busy"}, ifc1.BUSY, 1);
        step();
        chk({tag, ".done"}, ifc1.DONE, 1);
        chk({tag, ".res"},  {ifc1.CARRY, ifc1.SUM}, exp);
        step();
        chk({tag, ".done_1cyc"}, ifc1.DONE, 0);
    endtask

    initial begin
        int pulses, done_edge, e;
        logic [7:0] s_at_done;
        logic       c_at_done;
        ifc8.START = 1'b0; ifc8.A = '0; ifc8.B = '0;
        ifc1.START = 1'b0; ifc1.A = '0; ifc1.B = '0;

        #12;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("rst.ready", ifc8.READY, 1);
        chk("rst.busy",  ifc8.BUSY, 0);
        chk("rst.done",  ifc8.DONE, 0);
        chk("rst.sum",   ifc8.SUM, 0);
        chk("rst.carry", ifc8.CARRY, 0);
        chk("rst1.ready", ifc1.READY, 1);

        op8("zero", 8'h00, 8'h00, 8'h00, 1'b0);
        op8("ff01", 8'hFF, 8'h01, 8'h00, 1'b1);
        op8("a55a", 8'hA5, 8'h5A, 8'hFF, 1'b0);
        op8("8080", 8'h80, 8'h80, 8'h00, 1'b1);

        // START pulsed while busy must not disturb the running add.
        ifc8.START = 1'b1; ifc8.A = 8'h0F; ifc8.B = 8'h01;
        step();
        ifc8.START = 1'b0;
        step(); step();
        ifc8.START = 1'b1; ifc8.A = 8'hFF; ifc8.B = 8'hFF;
        step();
        ifc8.START = 1'b0; ifc8.A = 8'h00; ifc8.B = 8'h00;
        pulses = 0; done_edge = 0; s_at_done = 8'h00; c_at_done = 1'b0;
        for (int k = 4; k < 16; k++) begin
            step();
            if (ifc8.DONE) begin
                pulses++; done_edge = k; s_at_done = ifc8.SUM; c_at_done = ifc8.CARRY;
            end
        end
        chk("ign.pulses", pulses, 1);
        chk("ign.edge",   done_edge, 8);
        chk("ign.sum",    s_at_done, 8'h10);
        chk("ign.carry",  c_at_done, 0);

        // Back-to-back: START held high through FIN.
        ifc8.START = 1'b1; ifc8.A = 8'h12; ifc8.B = 8'h34;
        step();
        e = 0;
        while (!ifc8.DONE && e < 20) begin step(); e++; end
        chk("b2b.lat1",   e, 8);
        chk("b2b.sum1",   ifc8.SUM, 8'h46);
        chk("b2b.carry1", ifc8.CARRY, 0);
        ifc8.A = 8'h7F; ifc8.B = 8'h01;
        step();
        ifc8.START = 1'b0; ifc8.A = 8'h00; ifc8.B = 8'h00;
        chk("b2b.reacc_busy", ifc8.BUSY, 1);
        chk("b2b.reacc_done", ifc8.DONE, 0);
        e = 0;
        while (!ifc8.DONE && e < 20) begin step(); e++; end
        chk("b2b.lat2",   e, 8);
        chk("b2b.sum2",   ifc8.SUM, 8'h80);
        chk("b2b.carry2", ifc8.CARRY, 0);
        step();
        chk("b2b.idle", ifc8.DONE, 0);

        // Asynchronous reset in the middle of a run.
        ifc8.START = 1'b1; ifc8.A = 8'hFF; ifc8.B = 8'hFF;
        step();
        ifc8.START = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        chk("mid.busy_pre", ifc8.BUSY, 1);
        RST_N = 1'b0;
        #1;
        chk("mid.ready", ifc8.READY, 1);
        chk("mid.busy",  ifc8.BUSY, 0);
        chk("mid.done",  ifc8.DONE, 0);
        chk("mid.sum",   ifc8.SUM, 0);
        chk("mid.carry", ifc8.CARRY, 0);
        step(); step();
        @(negedge CLK);
        RST_N = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ifc8.DONE) pulses++;
        end
        chk("mid.no_done", pulses, 0);
        op8("post", 8'h01, 8'h02, 8'h03, 1'b0);

        op1("w1_00", 1'b0, 1'b0, 2'b00);
        op1("w1_01", 1'b0, 1'b1, 2'b01);
        op1("w1_10", 1'b1, 1'b0, 2'b01);
        op1("w1_11", 1'b1, 1'b1, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
